rggen_bus_arbiter: RTL and testbench

//  Shares one external rggen bus (request/address/direction/write_data/write_strobe ->

---
 rtl/rggen_rtl_pkg.sv | 27 ++
 rtl/rggen_round_robin_arbiter.sv | 51 +++++
 rtl/rggen_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared rggen types: bus direction/status encodings, the bus arbiter FSM
// states and the arbiter index-width helper.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    RGGEN_ARB_IDLE,
    RGGEN_ARB_BUSY
  } rggen_arbiter_state;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int rggen_arb_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin picker: first set request scanning from i_ptr
// upward with wrap. The pointer itself is owned by the parent.
module rggen_round_robin_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int N = 2
)(
  input  logic [N-1:0]                        i_request,
  input  logic [rggen_arb_index_width(N)-1:0] i_ptr,
  output logic [N-1:0]                        o_grant,
  output logic [rggen_arb_index_width(N)-1:0] o_index,
  output logic                                o_valid
);

  localparam int IW = rggen_arb_index_width(N);

  logic          w_found_hi;
  logic          w_found_lo;
  logic [IW-1:0] w_index_hi;
  logic [IW-1:0] w_index_lo;

  // Two scans replace the modulo walk: lowest request at/above the pointer,
  // else lowest request overall (which is the first one after wrapping).
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_index_hi = '0;
    w_index_lo = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!w_found_hi && i_request[j] && (j >= 32'(i_ptr))) begin
        w_found_hi = 1'b1;
        w_index_hi = IW'(j);
      end
      if (!w_found_lo && i_request[j]) begin
        w_found_lo = 1'b1;
        w_index_lo = IW'(j);
      end
    end
  end

  // Winner index and its one-hot grant.
  always_comb begin
    o_valid = w_found_lo;
    o_index = w_found_hi ? w_index_hi : w_index_lo;
    o_grant = '0;
    for (int unsigned j = 0; j < N; j++) begin
      o_grant[j] = w_found_lo && (o_index == IW'(j));
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one downstream rggen bus between N requesters.
// A grant is held for the whole transaction until downstream done.
// Optional watchdog: define RGGEN_BUS_ARBITER_TIMEOUT_EN to force a
// SLAVE_ERROR completion after TIMEOUT_CYCLES busy cycles.
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int N              = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0]                 i_request,
  input  logic [N*ADDRESS_WIDTH-1:0]   i_address,
  input  logic [N-1:0]                 i_direction,
  input  logic [N*DATA_WIDTH-1:0]      i_write_data,
  input  logic [N*DATA_WIDTH/8-1:0]    i_write_strobe,
  output logic [N-1:0]                 o_done,
  output logic [DATA_WIDTH-1:0]        o_read_data,
  output logic [1:0]                   o_status,
  output logic [N-1:0]                 o_grant,
  output logic                         o_bus_request,
  output logic [ADDRESS_WIDTH-1:0]     o_bus_address,
  output logic                         o_bus_direction,
  output logic [DATA_WIDTH-1:0]        o_bus_write_data,
  output logic [DATA_WIDTH/8-1:0]      o_bus_write_strobe,
  input  logic                         i_bus_done,
  input  logic [DATA_WIDTH-1:0]        i_bus_read_data,
  input  logic [1:0]                   i_bus_status
);

  localparam int IW = rggen_arb_index_width(N);
  localparam int SW = DATA_WIDTH / 8;

  rggen_arbiter_state       r_state;
  rggen_arbiter_state       w_next_state;
  logic [IW-1:0]            r_ptr;
  logic [N-1:0]             r_grant;
  logic                     r_bus_request;
  logic [ADDRESS_WIDTH-1:0] r_bus_address;
  logic                     r_bus_direction;
  logic [DATA_WIDTH-1:0]    r_bus_write_data;
  logic [SW-1:0]            r_bus_write_strobe;

  logic [N-1:0]             w_rr_grant;
  logic [IW-1:0]            w_rr_index;
  logic                     w_rr_valid;
  logic [IW-1:0]            w_next_ptr;
  logic                     w_start;
  logic                     w_complete;
  logic                     w_timeout;

  logic [ADDRESS_WIDTH-1:0] w_sel_address;
  logic                     w_sel_direction;
  logic [DATA_WIDTH-1:0]    w_sel_write_data;
  logic [SW-1:0]            w_sel_write_strobe;

  rggen_round_robin_arbiter #(
    .N (N)
  ) u_rr (
    .i_request (i_request),
    .i_ptr     (r_ptr),
    .o_grant   (w_rr_grant),
    .o_index   (w_rr_index),
    .o_valid   (w_rr_valid)
  );

  assign w_start    = (r_state == RGGEN_ARB_IDLE) && w_rr_valid;
  assign w_complete = (r_state == RGGEN_ARB_BUSY) && (i_bus_done || w_timeout);
  assign w_next_ptr = (w_rr_index == IW'(N - 1)) ? '0 : w_rr_index + IW'(1);

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_timer;

  // Busy-cycle counter; held at zero while idle so it starts at 0 on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == RGGEN_ARB_BUSY) begin
      r_timer <= r_timer + TW'(1);
    end else begin
      r_timer <= '0;
    end
  end

  assign w_timeout = (r_state == RGGEN_ARB_BUSY) && (r_timer == TW'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // And-or mux of the winning requester's transaction fields.
  always_comb begin
    w_sel_address      = '0;
    w_sel_direction    = 1'b0;
    w_sel_write_data   = '0;
    w_sel_write_strobe = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_rr_grant[k]) begin
        w_sel_address      = w_sel_address      | i_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel_direction    = w_sel_direction    | i_direction[k];
        w_sel_write_data   = w_sel_write_data   | i_write_data[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_write_strobe = w_sel_write_strobe | i_write_strobe[k*SW +: SW];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RGGEN_ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: idle until a request, busy until done (or watchdog).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RGGEN_ARB_IDLE: if (w_rr_valid)               w_next_state = RGGEN_ARB_BUSY;
      RGGEN_ARB_BUSY: if (i_bus_done || w_timeout)  w_next_state = RGGEN_ARB_IDLE;
      default:                                      w_next_state = RGGEN_ARB_IDLE;
    endcase
  end

  // Latch the winner's transaction on grant; clear everything on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr              <= '0;
      r_grant            <= '0;
      r_bus_request      <= 1'b0;
      r_bus_address      <= '0;
      r_bus_direction    <= RGGEN_READ;
      r_bus_write_data   <= '0;
      r_bus_write_strobe <= '0;
    end else if (w_start) begin
      r_ptr              <= w_next_ptr;
      r_grant            <= w_rr_grant;
      r_bus_request      <= 1'b1;
      r_bus_address      <= w_sel_address;
      r_bus_direction    <= w_sel_direction;
      r_bus_write_data   <= w_sel_write_data;
      r_bus_write_strobe <= w_sel_write_strobe;
    end else if (w_complete) begin
      r_grant            <= '0;
      r_bus_request      <= 1'b0;
      r_bus_address      <= '0;
      r_bus_direction    <= RGGEN_READ;
      r_bus_write_data   <= '0;
      r_bus_write_strobe <= '0;
    end
  end

  // Completion response to the owner; a real done beats a watchdog expiry.
  always_comb begin
    o_done      = '0;
    o_read_data = '0;
    o_status    = RGGEN_OKAY;
    if (w_complete) begin
      o_done = r_grant;
      if (i_bus_done) begin
        o_read_data = i_bus_read_data;
        o_status    = i_bus_status;
      end else begin
        o_status    = RGGEN_SLAVE_ERROR;
      end
    end
  end

  assign o_grant            = r_grant;
  assign o_bus_request      = r_bus_request;
  assign o_bus_address      = r_bus_address;
  assign o_bus_direction    = r_bus_direction;
  assign o_bus_write_data   = r_bus_write_data;
  assign o_bus_write_strobe = r_bus_write_strobe;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Self-checking bench for rggen_bus_arbiter (N=3). Expected grants come from
// a round-robin reference model kept here; the watchdog section follows
// RGGEN_BUS_ARBITER_TIMEOUT_EN.
module tb_rggen_bus_arbiter;
  import rggen_rtl_pkg::*;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      i_request;
  logic [N*AW-1:0]   i_address;
  logic [N-1:0]      i_direction;
  logic [N*DW-1:0]   i_write_data;
  logic [N*SW-1:0]   i_write_strobe;
  logic [N-1:0]      o_done;
  logic [DW-1:0]     o_read_data;
  logic [1:0]        o_status;
  logic [N-1:0]      o_grant;
  logic              o_bus_request;
  logic [AW-1:0]     o_bus_address;
  logic              o_bus_direction;
  logic [DW-1:0]     o_bus_write_data;
  logic [SW-1:0]     o_bus_write_strobe;
  logic              i_bus_done;
  logic [DW-1:0]     i_bus_read_data;
  logic [1:0]        i_bus_status;

  rggen_bus_arbiter #(
    .N              (N),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_request          (i_request),
    .i_address          (i_address),
    .i_direction        (i_direction),
    .i_write_data       (i_write_data),
    .i_write_strobe     (i_write_strobe),
    .o_done             (o_done),
    .o_read_data        (o_read_data),
    .o_status           (o_status),
    .o_grant            (o_grant),
    .o_bus_request      (o_bus_request),
    .o_bus_address      (o_bus_address),
    .o_bus_direction    (o_bus_direction),
    .o_bus_write_data   (o_bus_write_data),
    .o_bus_write_strobe (o_bus_write_strobe),
    .i_bus_done         (i_bus_done),
    .i_bus_read_data    (i_bus_read_data),
    .i_bus_status       (i_bus_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input logic dir, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s);
    i_address[k*AW +: AW]      = a;
    i_direction[k]             = dir;
    i_write_data[k*DW +: DW]   = d;
    i_write_strobe[k*SW +: SW] = s;
  endtask

  // Reference: first requester found walking ptr, ptr+1, ... modulo N.
  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      if (req[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One complete transaction for whoever the model says wins next.
  task automatic run_txn(input int lat, input logic [DW-1:0] rdata, input logic [1:0] st,
                         input bit drop, input bit perturb, input logic [N-1:0] raise,
                         output int w);
    logic [AW-1:0] ea;
    logic          edir;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    w = pick(i_request, ptr);
    if (w < 0) return;
    ea   = i_address[w*AW +: AW];
    edir = i_direction[w];
    ed   = i_write_data[w*DW +: DW];
    es   = i_write_strobe[w*SW +: SW];
    @(posedge clk); #1;
    check("grant", o_grant, 64'(1) << w);
    check("bus_request", o_bus_request, 1);
    check("bus_address", o_bus_address, ea);
    check("bus_direction", o_bus_direction, edir);
    check("bus_write_data", o_bus_write_data, ed);
    check("bus_write_strobe", o_bus_write_strobe, es);
    check("done_early", o_done, 0);
    ptr = (w + 1) % N;
    if (perturb) begin
      i_address[w*AW +: AW]    = ~ea;
      i_direction[w]           = ~edir;
      i_write_data[w*DW +: DW] = ~ed;
    end
    if (drop) i_request[w] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (raise[k] && !i_request[k] && k != w) begin
        load(k, 1'($urandom), AW'($urandom), $urandom, SW'($urandom));
        i_request[k] = 1'b1;
      end
    end
    repeat (lat) begin
      @(posedge clk); #1;
      check("done_wait", o_done, 0);
    end
    check("frozen_address", o_bus_address, ea);
    check("frozen_direction", o_bus_direction, edir);
    check("frozen_data", o_bus_write_data, ed);
    i_bus_done      = 1'b1;
    i_bus_read_data = rdata;
    i_bus_status    = st;
    #1;
    check("done", o_done, 64'(1) << w);
    check("read_data", o_read_data, rdata);
    check("status", o_status, st);
    @(posedge clk); #1;
    i_bus_done   = 1'b0;
    i_request[w] = 1'b0;
    check("grant_cleared", o_grant, 0);
    check("bus_request_cleared", o_bus_request, 0);
    check("bus_address_cleared", o_bus_address, 0);
    check("done_cleared", o_done, 0);
  endtask

  initial begin
    int w;
    rst_n           = 1'b0;
    i_request       = '0;
    i_address       = '0;
    i_direction     = '0;
    i_write_data    = '0;
    i_write_strobe  = '0;
    i_bus_done      = 1'b0;
    i_bus_read_data = '0;
    i_bus_status    = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", o_grant, 0);
    check("rst_bus_request", o_bus_request, 0);
    check("rst_bus_address", o_bus_address, 0);
    check("rst_bus_direction", o_bus_direction, 0);
    check("rst_done", o_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Done while idle is ignored.
    i_bus_done = 1'b1;
    i_bus_read_data = 32'h5555_AAAA;
    #1;
    check("idle_done", o_done, 0);
    @(posedge clk); #1;
    check("idle_grant", o_grant, 0);
    check("idle_bus_request", o_bus_request, 0);
    i_bus_done = 1'b0;

    // Single READ from requester 0.
    load(0, RGGEN_READ, 16'h0010, 32'h0, 4'h0);
    i_request = 3'b001;
    run_txn(2, 32'hCAFE_F00D, RGGEN_OKAY, 0, 0, '0, w);
    check("t1_winner", w, 0);

    // WRITE from requester 2.
    load(2, RGGEN_WRITE, 16'hBEEF, 32'h1234_5678, 4'b0011);
    i_request = 3'b100;
    run_txn(1, 32'h0, RGGEN_OKAY, 0, 0, '0, w);
    check("t3_winner", w, 2);

    // Two simultaneous requesters alternate.
    load(0, RGGEN_READ, 16'h0100, 32'h0, 4'h0);
    load(1, RGGEN_WRITE, 16'h0200, 32'hA5A5_5A5A, 4'hF);
    for (int k = 0; k < 4; k++) begin
      i_request[1:0] = 2'b11;
      run_txn(k, $urandom, RGGEN_OKAY, 0, 0, '0, w);
      check("rr_order", w, k % 2);
    end

    // Upstream changes while granted; a new requester waits its turn.
    load(0, RGGEN_READ, 16'h0300, 32'h0, 4'h0);
    i_request = 3'b001;
    run_txn(3, 32'h1111_2222, RGGEN_EXOKAY, 0, 1, 3'b010, w);
    check("t4_first", w, 0);
    run_txn(1, 32'h3333_4444, RGGEN_OKAY, 1, 0, '0, w);
    check("t4_second", w, 1);

    // Reset in the middle of a transaction.
    load(0, RGGEN_WRITE, 16'h0400, 32'hFFFF_0000, 4'hC);
    load(1, RGGEN_READ, 16'h0500, 32'h0, 4'h0);
    i_request = 3'b001;
    @(posedge clk); #1;
    check("t5_grant", o_grant, 3'b001);
    i_request[1] = 1'b1;
    #1 rst_n = 1'b0;
    #1 i_bus_done = 1'b1;
    i_bus_read_data = 32'h9999_8888;
    #1;
    check("t5_grant_rst", o_grant, 0);
    check("t5_bus_request_rst", o_bus_request, 0);
    check("t5_bus_address_rst", o_bus_address, 0);
    check("t5_done_rst", o_done, 0);
    check("t5_read_data_rst", o_read_data, 0);
    @(posedge clk); #1;
    check("t5_grant_held_rst", o_grant, 0);
    i_bus_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
    i_request = 3'b011;
    run_txn(0, 32'h0, RGGEN_OKAY, 0, 0, '0, w);
    check("t5_after_rst_first", w, 0);
    run_txn(2, 32'h7777_6666, RGGEN_DECODE_ERROR, 0, 0, '0, w);
    check("t5_after_rst_second", w, 1);

    // Randomized traffic against the round-robin model.
    for (int r = 0; r < 24; r++) begin
      logic [N-1:0] add;
      add = N'($urandom_range(0, 7));
      if ((i_request | add) == '0) add = N'(1) << $urandom_range(0, N - 1);
      for (int k = 0; k < N; k++) begin
        if (add[k] && !i_request[k]) begin
          load(k, 1'($urandom), AW'($urandom), $urandom, SW'($urandom));
          i_request[k] = 1'b1;
        end
      end
      run_txn($urandom_range(0, 3), $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
              N'($urandom_range(0, 7)), w);
    end
    // Drain whatever is still pending.
    while (i_request != '0) begin
      run_txn(0, $urandom, RGGEN_OKAY, 0, 0, '0, w);
    end

    // Slave that never answers.
    load(2, RGGEN_READ, 16'h0600, 32'h0, 4'h0);
    i_request = 3'b100;
    i_bus_read_data = 32'hDEAD_BEEF;
    i_bus_status = RGGEN_OKAY;
    @(posedge clk); #1;
    check("to_grant", o_grant, 3'b100);
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    repeat (TO) begin
      check("to_wait", o_done, 0);
      @(posedge clk); #1;
    end
    check("to_done", o_done, 3'b100);
    check("to_status", o_status, RGGEN_SLAVE_ERROR);
    check("to_read_data", o_read_data, 0);
    @(posedge clk); #1;
    i_request = '0;
    check("to_grant_cleared", o_grant, 0);
    check("to_bus_request_cleared", o_bus_request, 0);
`else
    repeat (100) @(posedge clk);
    #1;
    check("nto_grant", o_grant, 3'b100);
    check("nto_bus_request", o_bus_request, 1);
    check("nto_done", o_done, 0);
    i_bus_done = 1'b1;
    #1;
    check("nto_late_done", o_done, 3'b100);
    check("nto_late_data", o_read_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    i_bus_done = 1'b0;
    i_request  = '0;
    check("nto_grant_cleared", o_grant, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
